// File: rtl/multi_pkg.sv
// Shared constants and helpers for the multi_u16 shift-and-add multiplier.
package multi_pkg;

   localparam int unsigned WIDTH  = 32'd16;
   localparam int unsigned BPS    = 32'd4;
   localparam int unsigned NSTAGE = WIDTH / BPS;
   localparam int unsigned PW     = 32'd2 * WIDTH;
   localparam int unsigned LAT    = NSTAGE + 32'd1;

   // One partial product: the multiplicand zero-extended to the full
   // product width, shifted to the weight of multiplier bit 'shift',
   // and gated by that multiplier bit.
   function automatic logic [PW-1:0] gated_pp(
      input logic [WIDTH-1:0] a,
      input logic             b_bit,
      input int unsigned      shift
   );
      logic [PW-1:0] ext;
      ext      = {{WIDTH{1'b0}}, a};
      gated_pp = b_bit ? (ext << shift) : {PW{1'b0}};
   endfunction

endpackage

// File: rtl/multi_stage.sv
// One accumulate stage of the multiplier pipeline. Adds the BPS partial
// products selected by multiplier bits STAGE*BPS .. STAGE*BPS+BPS-1 to the
// incoming running sum and registers the sum together with both operands.
module multi_stage
   import multi_pkg::*;
#(
   parameter int unsigned STAGE = 32'd0
) (
   input  logic             sclk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [PW-1:0]    i_sum,
   output logic [WIDTH-1:0] o_a,
   output logic [WIDTH-1:0] o_b,
   output logic [PW-1:0]    o_sum
);

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [PW-1:0]    r_sum;

   // Adder chain: w_acc[j+1] = w_acc[j] + gated partial product for bit j.
   logic [PW-1:0] w_acc [0:BPS];

   assign w_acc[0] = i_sum;

   for (genvar j = 0; j < BPS; j++) begin : g_pp
      assign w_acc[j+1] = w_acc[j]
                        + gated_pp(i_a, i_b[STAGE*BPS + j], STAGE*BPS + j);
   end

   // Stage register: forward operands and the updated sum, cleared by reset.
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         r_a   <= {WIDTH{1'b0}};
         r_b   <= {WIDTH{1'b0}};
         r_sum <= {PW{1'b0}};
      end else begin
         r_a   <= i_a;
         r_b   <= i_b;
         r_sum <= w_acc[BPS];
      end
   end

   assign o_a   = r_a;
   assign o_b   = r_b;
   assign o_sum = r_sum;

endmodule

// File: rtl/multi_u16.sv
// Unsigned pipelined shift-and-add multiplier: an operand input register
// followed by NSTAGE accumulate stages. Accepts a new pair every cycle;
// the last stage's sum register is the product output.
module multi_u16
   import multi_pkg::*;
(
   input  logic             sclk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [PW-1:0]    out_rlst
);

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;

   // Inter-stage links; index 0 is the input register, index NSTAGE the last stage.
   logic [WIDTH-1:0] w_a   [0:NSTAGE];
   logic [WIDTH-1:0] w_b   [0:NSTAGE];
   logic [PW-1:0]    w_sum [0:NSTAGE];

   // Input register: capture the operand pair every cycle, cleared by reset.
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         r_a <= {WIDTH{1'b0}};
         r_b <= {WIDTH{1'b0}};
      end else begin
         r_a <= in_a;
         r_b <= in_b;
      end
   end

   assign w_a[0]   = r_a;
   assign w_b[0]   = r_b;
   assign w_sum[0] = {PW{1'b0}};

   for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      multi_stage #(
         .STAGE (k)
      ) u_stage (
         .sclk  (sclk),
         .rst_n (rst_n),
         .i_a   (w_a[k]),
         .i_b   (w_b[k]),
         .i_sum (w_sum[k]),
         .o_a   (w_a[k+1]),
         .o_b   (w_b[k+1]),
         .o_sum (w_sum[k+1])
      );
   end

   assign out_rlst = w_sum[NSTAGE];

   // The last stage forwards its operands like every other stage, but
   // nothing downstream consumes them.
   logic w_unused_ops;
   assign w_unused_ops = ^{w_a[NSTAGE], w_b[NSTAGE]};

endmodule

// File: tb/tb_multi_u16.sv
// Self-checking bench for multi_u16: a reference delay line of exact
// products, compared against out_rlst one step after every rising edge.
module tb_multi_u16;

   localparam int LAT = 5;

   logic        sclk;
   logic        rst_n;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic [31:0] out_rlst;

   int n_vec;
   int n_err;

   // Products still in flight; the front is what should be visible next.
   logic [31:0] exp_q [$];

   multi_u16 dut (
      .sclk     (sclk),
      .rst_n    (rst_n),
      .in_a     (in_a),
      .in_b     (in_b),
      .out_rlst (out_rlst)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   // Reference after reset: an empty pipeline holds LAT-1 zero products.
   task automatic model_reset();
      exp_q.delete();
      for (int i = 0; i < LAT - 1; i++) exp_q.push_back(32'd0);
   endtask

   // Apply one operand pair for one cycle; return observed and expected.
   task automatic step(input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] obs, output logic [31:0] exp);
      in_a = a;
      in_b = b;
      @(posedge sclk);
      #1;
      exp_q.push_back(32'(a) * 32'(b));
      exp = exp_q.pop_front();
      obs = out_rlst;
   endtask

   task automatic test_reset();
      logic [31:0] obs, exp;
      rst_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_a = 16'($urandom);
         in_b = 16'($urandom);
         @(posedge sclk);
         #1;
         n_vec++;
         if (out_rlst !== 32'd0) begin
            n_err++;
            $display("FAIL reset_hold cycle %0d: got %h expected 00000000", i, out_rlst);
         end
      end
      @(negedge sclk);
      in_a  = 16'd0;
      in_b  = 16'd0;
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 8; i++) begin
         step(16'd0, 16'd0, obs, exp);
         n_vec++;
         if (obs !== 32'd0 || obs !== exp) begin
            n_err++;
            $display("FAIL reset_release cycle %0d: got %h expected %h", i, obs, exp);
         end
      end
   endtask

   task automatic test_single();
      logic [31:0] obs, exp, want;
      for (int i = 0; i < 10; i++) begin
         if (i == 0) step(16'd3, 16'd5, obs, exp);
         else        step(16'd0, 16'd0, obs, exp);
         want = (i == LAT - 1) ? 32'd15 : 32'd0;
         n_vec++;
         if (obs !== want || obs !== exp) begin
            n_err++;
            $display("FAIL single cycle %0d: got %h expected %h", i, obs, want);
         end
      end
   endtask

   task automatic test_boundary();
      logic [15:0] ba [4];
      logic [15:0] bb [4];
      logic [31:0] bp [4];
      logic [31:0] obs, exp;
      ba = '{16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h0001};
      bb = '{16'h7FFF, 16'hFFFF, 16'h0000, 16'hABCD};
      bp = '{32'h3FFF0001, 32'hFFFE0001, 32'h00000000, 32'h0000ABCD};
      for (int i = 0; i < 4 + LAT; i++) begin
         if (i < 4) step(ba[i], bb[i], obs, exp);
         else       step(16'd0, 16'd0, obs, exp);
         n_vec++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL boundary cycle %0d: got %h expected %h", i, obs, exp);
         end
         if (i >= LAT - 1 && i < LAT + 3) begin
            n_vec++;
            if (obs !== bp[i-(LAT-1)]) begin
               n_err++;
               $display("FAIL boundary_const %0d: got %h expected %h",
                        i - (LAT - 1), obs, bp[i-(LAT-1)]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] obs, exp, sq;
      for (int i = 0; i < 10 + LAT; i++) begin
         if (i < 10) step(16'(i + 1), 16'(i + 1), obs, exp);
         else        step(16'd0, 16'd0, obs, exp);
         n_vec++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL back_to_back cycle %0d: got %h expected %h", i, obs, exp);
         end
         if (i >= LAT - 1 && i < LAT + 9) begin
            sq = 32'((i - LAT + 2) * (i - LAT + 2));
            n_vec++;
            if (obs !== sq) begin
               n_err++;
               $display("FAIL back_to_back_square cycle %0d: got %0d expected %0d", i, obs, sq);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] obs, exp;
      for (int i = 0; i < 4; i++) begin
         step(16'($urandom_range(65535, 1)), 16'($urandom_range(65535, 1)), obs, exp);
         n_vec++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL mid_reset_fill cycle %0d: got %h expected %h", i, obs, exp);
         end
      end
      #3;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (out_rlst !== 32'd0) begin
         n_err++;
         $display("FAIL mid_reset_async: got %h expected 00000000", out_rlst);
      end
      model_reset();
      for (int i = 0; i < 2; i++) begin
         in_a = 16'($urandom);
         in_b = 16'($urandom);
         @(posedge sclk);
         #1;
         n_vec++;
         if (out_rlst !== 32'd0) begin
            n_err++;
            $display("FAIL mid_reset_hold cycle %0d: got %h expected 00000000", i, out_rlst);
         end
      end
      @(negedge sclk);
      in_a  = 16'd0;
      in_b  = 16'd0;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(16'd0, 16'd0, obs, exp);
         n_vec++;
         if (obs !== 32'd0 || obs !== exp) begin
            n_err++;
            $display("FAIL mid_reset_after cycle %0d: got %h expected %h", i, obs, exp);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] obs, exp;
      logic [15:0] v;
      for (int i = 0; i < 255 + LAT; i++) begin
         v = (i < 255) ? 16'($urandom % 32'd32768) : 16'd0;
         step(v, v, obs, exp);
         n_vec++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL random cycle %0d: got %h expected %h", i, obs, exp);
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      in_a  = 16'd0;
      in_b  = 16'd0;
      model_reset();
      test_reset();
      test_single();
      test_boundary();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
